// File: rtl/speck_pkg.sv
// Shared definitions for the Speck64 byte-stream controller.
// Holds the default word width, block size in bytes, the controller state
// encoding and the big-endian byte-position helper used for (de)serialisation.
package speck_pkg;

    // Speck64 uses two 32-bit words per block.
    localparam int SPECK_W   = 32;
    localparam int BLK_BYTES = SPECK_W / 4;

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TX    = 2'd3
    } ctrl_state_t;

    // Bit offset of byte number idx inside an nbytes-wide block when byte 0
    // is the most significant byte (wire order = big-endian).
    function automatic int be_byte_lsb(input int idx, input int nbytes);
        return (nbytes - 1 - idx) * 8;
    endfunction

endpackage

// File: rtl/speck_dec_ctrl.sv
// speck_dec_ctrl: sequences a Speck64 decryptor between a UART receiver and
// transmitter. Packs BLK_BYTES received ciphertext bytes (big-endian, ct_x
// first) into {dec_ct_x, dec_ct_y}, pulses dec_start, waits for dec_done,
// then streams {dec_pt_x, dec_pt_y} out MSB byte first over tx_valid/tx_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_data, rx_valid     received byte strobe (single cycle)
//   tx_data, tx_valid,    transmit byte, held while tx_ready is low
//   tx_ready
//   dec_start             one-cycle start to the decryptor
//   dec_ct_x, dec_ct_y    ciphertext words, stable from START until next block
//   dec_done              decryptor done level
//   dec_pt_x, dec_pt_y    plaintext words, valid while dec_done is high
//   busy                  high while a block is in START, WAIT or TX
//   overrun               one-cycle pulse: a byte arrived outside RX and was dropped
//   rx_timeout            one-cycle pulse: a partial RX block was discarded
//   blk_count             completed blocks, wraps
//
// All outputs are registered.
module speck_dec_ctrl
    import speck_pkg::*;
#(
    parameter int W       = SPECK_W,
    parameter int TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         dec_start,
    output logic [W-1:0] dec_ct_x,
    output logic [W-1:0] dec_ct_y,
    input  logic         dec_done,
    input  logic [W-1:0] dec_pt_x,
    input  logic [W-1:0] dec_pt_y,
    output logic         busy,
    output logic         overrun,
    output logic         rx_timeout,
    output logic [15:0]  blk_count
);

    localparam int NB = (2 * W) / 8;
    localparam int IW = $clog2(NB);
    // One bit is enough when the timeout is disabled; the counter then never moves.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    ctrl_state_t     state_q;
    logic [IW-1:0]   idx_q;       // byte index, shared by RX packing and TX serialising
    logic [2*W-9:0]  rx_blk_q;    // the first NB-1 bytes; the last byte goes straight to dec_ct
    logic [2*W-1:0]  tx_blk_q;
    logic [CW-1:0]   idle_q;

    logic            idle_expire;

    // The timeout fires at the end of the TIMEOUT-th idle cycle. A byte
    // arriving in that same cycle wins and the partial block is kept.
    always_comb begin
        idle_expire = 1'b0;
        if (TIMEOUT > 0 && state_q == ST_RX && idx_q != '0 && !rx_valid &&
            32'(idle_q) == 32'(TIMEOUT - 1)) begin
            idle_expire = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RX;
            idx_q      <= '0;
            rx_blk_q   <= '0;
            tx_blk_q   <= '0;
            idle_q     <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            dec_start  <= 1'b0;
            dec_ct_x   <= '0;
            dec_ct_y   <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            rx_timeout <= 1'b0;
            blk_count  <= 16'h0000;
        end else begin
            dec_start  <= 1'b0;
            rx_timeout <= 1'b0;
            // Any byte offered while a block is in flight is lost.
            overrun    <= rx_valid && (state_q != ST_RX);

            case (state_q)
                ST_RX: begin
                    if (rx_valid) begin
                        idle_q   <= '0;
                        rx_blk_q <= {rx_blk_q[2*W-17:0], rx_data};
                        if (idx_q == LAST_IDX) begin
                            {dec_ct_x, dec_ct_y} <= {rx_blk_q, rx_data};
                            idx_q     <= '0;
                            dec_start <= 1'b1;
                            busy      <= 1'b1;
                            state_q   <= ST_START;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (idle_expire) begin
                        idx_q      <= '0;
                        idle_q     <= '0;
                        rx_blk_q   <= '0;
                        rx_timeout <= 1'b1;
                    end else if (TIMEOUT > 0 && idx_q != '0) begin
                        idle_q <= idle_q + 1'b1;
                    end
                end

                // dec_done may still be high from the previous block here;
                // the decryptor drops it when it accepts this start.
                ST_START: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (dec_done) begin
                        tx_blk_q <= {dec_pt_x, dec_pt_y};
                        tx_data  <= dec_pt_x[W-1 -: 8];
                        tx_valid <= 1'b1;
                        state_q  <= ST_TX;
                    end
                end

                // tx_valid is always high here; tx_data only moves on acceptance.
                ST_TX: begin
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            tx_valid  <= 1'b0;
                            tx_data   <= 8'h00;
                            idx_q     <= '0;
                            busy      <= 1'b0;
                            blk_count <= blk_count + 16'd1;
                            state_q   <= ST_RX;
                        end else begin
                            tx_data <= tx_blk_q[be_byte_lsb(int'(idx_q) + 1, NB) +: 8];
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_RX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speck_dec_ctrl.sv
module tb_speck_dec_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dec_start;
    logic [31:0] dec_ct_x;
    logic [31:0] dec_ct_y;
    logic        dec_done;
    logic [31:0] dec_pt_x;
    logic [31:0] dec_pt_y;
    logic        busy;
    logic        overrun;
    logic        rx_timeout;
    logic [15:0] blk_count;

    int checks = 0;
    int errors = 0;

    // Published Speck64/128 vector (key 1b1a1918 13121110 0b0a0908 03020100).
    logic [7:0] ct_b [8] = '{8'h8c, 8'h6f, 8'ha5, 8'h48, 8'h45, 8'h4e, 8'h02, 8'h8b};
    logic [7:0] pt_b [8] = '{8'h3b, 8'h72, 8'h65, 8'h74, 8'h74, 8'h75, 8'h43, 8'h2d};
    localparam logic [63:0] CT_BLK = 64'h8c6fa548_454e028b;
    localparam logic [63:0] PT_BLK = 64'h3b726574_7475432d;

    speck_dec_ctrl #(.W(32), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dec_start  (dec_start),
        .dec_ct_x   (dec_ct_x),
        .dec_ct_y   (dec_ct_y),
        .dec_done   (dec_done),
        .dec_pt_x   (dec_pt_x),
        .dec_pt_y   (dec_pt_y),
        .busy       (busy),
        .overrun    (overrun),
        .rx_timeout (rx_timeout),
        .blk_count  (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for speck_decryptor: knows only the one published vector and
    // returns a recognisably wrong block for anything else. dec_done rises
    // 27 cycles after the dec_start cycle and drops when a start is accepted.
    function automatic logic [63:0] model_dec(input logic [63:0] ct);
        if (ct == CT_BLK) return PT_BLK;
        return 64'hdeadbeef_0badf00d;
    endfunction

    logic [4:0] m_cnt;
    logic       m_run;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_done <= 1'b0;
            dec_pt_x <= 32'h0;
            dec_pt_y <= 32'h0;
            m_run    <= 1'b0;
            m_cnt    <= 5'd0;
        end else if (dec_start) begin
            dec_done <= 1'b0;
            m_run    <= 1'b1;
            m_cnt    <= 5'd26;
        end else if (m_run) begin
            if (m_cnt == 5'd1) begin
                dec_done             <= 1'b1;
                m_run                <= 1'b0;
                {dec_pt_x, dec_pt_y} <= model_dec({dec_ct_x, dec_ct_y});
            end
            m_cnt <= m_cnt - 5'd1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_block();
        for (int i = 0; i < 8; i++) send_byte(ct_b[i]);
    endtask

    // Starts in the START cycle. Collects the 8 TX bytes, counting busy cycles.
    // slow: tx_ready high one cycle in three. inject: rx_valid during WAIT and TX.
    task automatic collect(input bit slow, input bit inject, output int busy_cyc);
        int          n;
        bit          holding;
        logic [7:0]  held;
        n        = 0;
        busy_cyc = 0;
        holding  = 1'b0;
        held     = 8'h00;
        for (int k = 0; k < 400 && n < 8; k++) begin
            tx_ready = slow ? (k % 3 == 0) : 1'b1;
            rx_valid = inject && (k == 5 || k == 30);
            rx_data  = 8'ha5;
            if (k == 1) chk("start_one_cycle", 64'(dec_start), 64'd0);
            if (inject && (k == 6 || k == 31)) chk("overrun_pulse", 64'(overrun), 64'd1);
            if (inject && (k == 7 || k == 32)) chk("overrun_clear", 64'(overrun), 64'd0);
            if (busy) busy_cyc++;
            if (holding) begin
                chk("tx_hold_valid", 64'(tx_valid), 64'd1);
                chk("tx_hold_data", 64'(tx_data), 64'(held));
            end
            holding = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    chk($sformatf("tx_byte%0d", n), 64'(tx_data), 64'(pt_b[n]));
                    n++;
                end else begin
                    holding = 1'b1;
                    held    = tx_data;
                end
            end
            tick();
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk("tx_byte_count", 64'(n), 64'd8);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, 64'({tx_data, tx_valid, dec_start, busy, overrun, rx_timeout, blk_count}), 64'd0);
        chk({tag, "_ct"}, {dec_ct_x, dec_ct_y}, 64'd0);
    endtask

    initial begin
        int bc;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();
        chk_idle_outputs("after_reset");

        // Basic block, tx_ready tied high, minimum turnaround.
        send_block();
        chk("start_after_last", 64'(dec_start), 64'd1);
        chk("busy_start", 64'(busy), 64'd1);
        chk("dec_ct", {dec_ct_x, dec_ct_y}, CT_BLK);
        collect(1'b0, 1'b0, bc);
        chk("turnaround", 64'(bc), 64'd36);
        chk("busy_done", 64'(busy), 64'd0);
        chk("tx_valid_done", 64'(tx_valid), 64'd0);
        chk("blk_count_1", 64'(blk_count), 64'd1);

        // Throttled transmitter.
        send_block();
        collect(1'b1, 1'b0, bc);
        chk("blk_count_2", 64'(blk_count), 64'd2);

        // Bytes offered during WAIT and TX are dropped with an overrun pulse.
        send_block();
        collect(1'b0, 1'b1, bc);
        chk("blk_count_3", 64'(blk_count), 64'd3);

        // Partial block times out after 20 idle cycles.
        for (int i = 0; i < 3; i++) send_byte(ct_b[i]);
        chk("timeout_idle0", 64'(rx_timeout), 64'd0);
        repeat (19) tick();
        chk("timeout_early", 64'(rx_timeout), 64'd0);
        tick();
        chk("timeout_pulse", 64'(rx_timeout), 64'd1);
        tick();
        chk("timeout_clear", 64'(rx_timeout), 64'd0);
        send_block();
        chk("dec_ct_after_timeout", {dec_ct_x, dec_ct_y}, CT_BLK);
        collect(1'b0, 1'b0, bc);
        chk("blk_count_4", 64'(blk_count), 64'd4);

        // A byte landing in the expiry cycle is kept and the timeout does not fire.
        for (int i = 0; i < 3; i++) send_byte(ct_b[i]);
        repeat (19) tick();
        send_byte(ct_b[3]);
        chk("timeout_suppressed", 64'(rx_timeout), 64'd0);
        for (int i = 4; i < 8; i++) send_byte(ct_b[i]);
        chk("start_after_expiry_byte", 64'(dec_start), 64'd1);
        chk("dec_ct_expiry_byte", {dec_ct_x, dec_ct_y}, CT_BLK);
        collect(1'b0, 1'b0, bc);
        chk("blk_count_5", 64'(blk_count), 64'd5);

        // Reset while waiting for the decryptor.
        send_block();
        repeat (5) tick();
        chk("busy_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        chk_idle_outputs("reset_in_wait");
        rst = 1'b0;
        tick();
        send_block();
        chk("dec_ct_after_rst", {dec_ct_x, dec_ct_y}, CT_BLK);
        collect(1'b0, 1'b0, bc);
        chk("turnaround_after_rst", 64'(bc), 64'd36);
        chk("blk_count_after_rst", 64'(blk_count), 64'd1);

        // blk_count wraps from 0xFFFF to 0.
        force dut.blk_count = 16'hffff;
        tick();
        release dut.blk_count;
        tick();
        chk("blk_count_preset", 64'(blk_count), 64'hffff);
        send_block();
        collect(1'b0, 1'b0, bc);
        chk("blk_count_wrap", 64'(blk_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
